ac_motor_gate_drive: RTL

Converts the one-hot switching-vector selection (U_0/U_1/U_2/U_7) and the active sector from the vector-control stage into six inverter gate signals, with dead time inserted on every leg. It sits directly downstream of the vector-control stage and drives the three-phase bridge. It guarantees that both switches of a leg are never on together, and that each off-to-on transition on a leg is preceded by exactly DEAD_TIME cycles with both gates off.

---
 rtl/ac_motor_gate_drive.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/ac_motor_gate_drive.sv
// ac_motor_gate_drive
// Turns the one-hot switching-vector selection (U_0/U_1/U_2/U_7) plus the
// active sector into six inverter gate drives. Every off-to-on transition on a
// leg is preceded by exactly DEAD_TIME cycles with both gates of that leg off.
//
// Parameters:
//   DEAD_TIME  both-off interval in CLK cycles (1 .. 2^DT_WIDTH-1)
//   DT_WIDTH   dead-time counter width
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   ENABLE                bridge enable; low forces every leg off
//   SECTOR[2:0]           active sector, legal 1..6
//   U_0, U_1, U_2, U_7    vector selection, one-hot or all-zero
//   GATE_xH / GATE_xL     high/low-side gate drives for legs A, B, C
//   BUSY                  some leg is in dead time
//   ERROR                 sticky illegal-input flag
//   FAULT_N               (only with AC_MOTOR_GATE_FAULT_EN) active-low
//                         desaturation/overcurrent fault, latched until reset
// Build option: define AC_MOTOR_GATE_FAULT_EN to add the FAULT_N input.

module ac_motor_gate_drive #(
  parameter int unsigned DEAD_TIME = 100,
  parameter int unsigned DT_WIDTH  = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ENABLE,
  input  logic [2:0] SECTOR,
  input  logic       U_0,
  input  logic       U_1,
  input  logic       U_2,
  input  logic       U_7,
`ifdef AC_MOTOR_GATE_FAULT_EN
  input  logic       FAULT_N,
`endif
  output logic       GATE_AH,
  output logic       GATE_AL,
  output logic       GATE_BH,
  output logic       GATE_BL,
  output logic       GATE_CH,
  output logic       GATE_CL,
  output logic       BUSY,
  output logic       ERROR
);

  localparam int unsigned NUM_LEGS = 3;
  localparam logic [DT_WIDTH-1:0] DT_LAST = DT_WIDTH'(DEAD_TIME - 1);

  typedef enum logic [1:0] {
    LEG_OFF  = 2'd0,
    LEG_DEAD = 2'd1,
    LEG_HIGH = 2'd2,
    LEG_LOW  = 2'd3
  } leg_state_t;

  // Space-vector table as {A,B,C}; out-of-range sectors give V0.
  function automatic logic [2:0] vec_of(input logic [2:0] sec);
    case (sec)
      3'd1:    vec_of = 3'b100;
      3'd2:    vec_of = 3'b110;
      3'd3:    vec_of = 3'b010;
      3'd4:    vec_of = 3'b011;
      3'd5:    vec_of = 3'b001;
      3'd6:    vec_of = 3'b101;
      default: vec_of = 3'b000;
    endcase
  endfunction

  logic [2:0] target_q;
  logic       err_q;
  logic [2:0] u_cnt;
  logic       illegal_c;
  logic       fault_c;
  logic       force_off_c;
  logic [2:0] sector_next_c;
  logic [2:0] leg_tgt_c;

  leg_state_t          state_q [NUM_LEGS];
  leg_state_t          state_d [NUM_LEGS];
  logic [DT_WIDTH-1:0] cnt_q   [NUM_LEGS];
  logic [DT_WIDTH-1:0] cnt_d   [NUM_LEGS];
  logic [NUM_LEGS-1:0] dest_q;
  logic [NUM_LEGS-1:0] dest_d;
  logic [NUM_LEGS-1:0] gate_h_q;
  logic [NUM_LEGS-1:0] gate_l_q;
  logic [NUM_LEGS-1:0] gate_h_d;
  logic [NUM_LEGS-1:0] gate_l_d;
  logic                busy_d;

  // Illegal selection: multiple U high, or a sector-relative vector with no sector.
  assign u_cnt     = 3'(U_0) + 3'(U_1) + 3'(U_2) + 3'(U_7);
  assign illegal_c = (u_cnt > 3'd1) ||
                     ((U_1 || U_2) && ((SECTOR == 3'd0) || (SECTOR == 3'd7)));
  assign sector_next_c = (SECTOR == 3'd6) ? 3'd1 : (SECTOR + 3'd1);

`ifdef AC_MOTOR_GATE_FAULT_EN
  logic fault_s1_q;
  logic fault_s2_q;
  logic fault_lat_q;

  // Two-flop synchronizer followed by a latch cleared only by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fault_s1_q  <= 1'b1;
      fault_s2_q  <= 1'b1;
      fault_lat_q <= 1'b0;
    end else begin
      fault_s1_q <= FAULT_N;
      fault_s2_q <= fault_s1_q;
      if (!fault_s2_q) fault_lat_q <= 1'b1;
    end
  end

  // The synchronized edge acts immediately so the legs drop on the latching edge.
  assign fault_c = fault_lat_q || !fault_s2_q;
`else
  assign fault_c = 1'b0;
`endif

  // An illegal sample drops the legs on the same edge that raises ERROR.
  assign force_off_c = !ENABLE || err_q || illegal_c || fault_c;

  // Leg index 0/1/2 maps to A/B/C, i.e. target bits 2/1/0.
  assign leg_tgt_c = {target_q[0], target_q[1], target_q[2]};

  // Target vector and sticky error flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      target_q <= 3'b000;
      err_q    <= 1'b0;
    end else begin
      err_q <= fault_c || (ENABLE && (err_q || illegal_c));
      if (!err_q && !illegal_c && !fault_c) begin
        if (U_0)      target_q <= 3'b000;
        else if (U_7) target_q <= 3'b111;
        else if (U_1) target_q <= vec_of(SECTOR);
        else if (U_2) target_q <= vec_of(sector_next_c);
      end
    end
  end

  // Leg state, dead-time counters and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_LEGS; i++) begin
        state_q[i] <= LEG_OFF;
        cnt_q[i]   <= '0;
      end
      dest_q   <= '0;
      gate_h_q <= '0;
      gate_l_q <= '0;
      BUSY     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LEGS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      dest_q   <= dest_d;
      gate_h_q <= gate_h_d;
      gate_l_q <= gate_l_d;
      BUSY     <= busy_d;
    end
  end

  // Per-leg next state; dest holds the side the leg will turn on after dead time.
  always_comb begin
    for (int i = 0; i < NUM_LEGS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
    end
    dest_d = dest_q;
    for (int i = 0; i < NUM_LEGS; i++) begin
      if (force_off_c) begin
        state_d[i] = LEG_OFF;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          LEG_OFF: begin
            state_d[i] = LEG_DEAD;
            cnt_d[i]   = '0;
            dest_d[i]  = leg_tgt_c[i];
          end
          LEG_DEAD: begin
            if (leg_tgt_c[i] != dest_q[i]) begin
              // Reversal inside dead time: start the full interval again.
              dest_d[i] = leg_tgt_c[i];
              cnt_d[i]  = '0;
            end else if (cnt_q[i] == DT_LAST) begin
              state_d[i] = dest_q[i] ? LEG_HIGH : LEG_LOW;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + DT_WIDTH'(1);
            end
          end
          LEG_HIGH: begin
            if (!leg_tgt_c[i]) begin
              state_d[i] = LEG_DEAD;
              cnt_d[i]   = '0;
              dest_d[i]  = 1'b0;
            end
          end
          LEG_LOW: begin
            if (leg_tgt_c[i]) begin
              state_d[i] = LEG_DEAD;
              cnt_d[i]   = '0;
              dest_d[i]  = 1'b1;
            end
          end
          default: begin
            state_d[i] = LEG_OFF;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Outputs decoded from next state only, so they register with the state.
  always_comb begin
    gate_h_d = '0;
    gate_l_d = '0;
    busy_d   = 1'b0;
    for (int i = 0; i < NUM_LEGS; i++) begin
      gate_h_d[i] = (state_d[i] == LEG_HIGH);
      gate_l_d[i] = (state_d[i] == LEG_LOW);
      if (state_d[i] == LEG_DEAD) busy_d = 1'b1;
    end
  end

  assign GATE_AH = gate_h_q[0];
  assign GATE_AL = gate_l_q[0];
  assign GATE_BH = gate_h_q[1];
  assign GATE_BL = gate_l_q[1];
  assign GATE_CH = gate_h_q[2];
  assign GATE_CL = gate_l_q[2];
  assign ERROR   = err_q;

endmodule
